// File: rtl/register_status_mp.sv
// Checkpointed register status table for rename: per-register busy bit and
// producing ROB tag, with same-cycle rename/commit bypass and branch snapshots.
module register_status_mp #(
    parameter int NREG   = 32,
    parameter int REGW   = $clog2(NREG),
    parameter int ROB    = 3,
    parameter int RENAME = 2,
    parameter int COMMIT = 2,
    parameter int NCKPT  = 4,
    parameter int CKW    = $clog2(NCKPT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RENAME-1:0]      ren_valid,
    input  logic [RENAME*REGW-1:0] ren_rd,
    input  logic [RENAME*ROB-1:0]  ren_rob,
    input  logic [RENAME*REGW-1:0] ren_rs1,
    input  logic [RENAME*REGW-1:0] ren_rs2,
    output logic [RENAME-1:0]      src1_busy,
    output logic [RENAME-1:0]      src2_busy,
    output logic [RENAME*ROB-1:0]  src1_rob,
    output logic [RENAME*ROB-1:0]  src2_rob,
    input  logic [COMMIT-1:0]      cm_valid,
    input  logic [COMMIT*REGW-1:0] cm_rd,
    input  logic [COMMIT*ROB-1:0]  cm_rob,
    input  logic                   ckpt_save,
    input  logic                   ckpt_restore,
    input  logic [CKW-1:0]         ckpt_id,
    input  logic                   flush,
    output logic [NREG-1:0]        busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [ROB-1:0]  tag_q [NREG];
    logic [ROB-1:0]  tag_d [NREG];

    logic [NREG-1:0] ck_busy_q [NCKPT];
    logic [NREG-1:0] ck_busy_d [NCKPT];
    logic [ROB-1:0]  ck_tag_q  [NCKPT][NREG];
    logic [ROB-1:0]  ck_tag_d  [NCKPT][NREG];

    logic [REGW-1:0] rd_w  [RENAME];
    logic [ROB-1:0]  rob_w [RENAME];
    logic [REGW-1:0] rs1_w [RENAME];
    logic [REGW-1:0] rs2_w [RENAME];
    logic [REGW-1:0] crd_w [COMMIT];
    logic [ROB-1:0]  crob_w[COMMIT];

    for (genvar g = 0; g < RENAME; g++) begin : g_ren
        assign rd_w[g]  = ren_rd[g*REGW +: REGW];
        assign rob_w[g] = ren_rob[g*ROB +: ROB];
        assign rs1_w[g] = ren_rs1[g*REGW +: REGW];
        assign rs2_w[g] = ren_rs2[g*REGW +: REGW];
    end

    for (genvar g = 0; g < COMMIT; g++) begin : g_cm
        assign crd_w[g]  = cm_rd[g*REGW +: REGW];
        assign crob_w[g] = cm_rob[g*ROB +: ROB];
    end

    // Commit clears only hit entries still owned by the committing tag.
    logic [NREG-1:0] lclr;
    logic [NREG-1:0] cclr [NCKPT];

    always_comb begin
        lclr = '0;
        for (int s = 0; s < NCKPT; s++) begin
            cclr[s] = '0;
        end
        for (int k = 0; k < COMMIT; k++) begin
            if (cm_valid[k] && crd_w[k] != '0) begin
                if (busy_q[crd_w[k]] && tag_q[crd_w[k]] == crob_w[k]) begin
                    lclr[crd_w[k]] = 1'b1;
                end
                for (int s = 0; s < NCKPT; s++) begin
                    if (ck_busy_q[s][crd_w[k]] &&
                        ck_tag_q[s][crd_w[k]] == crob_w[k]) begin
                        cclr[s][crd_w[k]] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        busy_d    = busy_q;
        tag_d     = tag_q;
        ck_busy_d = ck_busy_q;
        ck_tag_d  = ck_tag_q;
        for (int r = 0; r < NREG; r++) begin
            if (lclr[r]) begin
                busy_d[r] = 1'b0;
                tag_d[r]  = '0;
            end
            for (int s = 0; s < NCKPT; s++) begin
                if (cclr[s][r]) begin
                    ck_busy_d[s][r] = 1'b0;
                    ck_tag_d[s][r]  = '0;
                end
            end
        end
        // Ascending lane order lets the youngest writer of an rd win.
        for (int i = 0; i < RENAME; i++) begin
            if (ren_valid[i] && rd_w[i] != '0) begin
                busy_d[rd_w[i]] = 1'b1;
                tag_d[rd_w[i]]  = rob_w[i];
            end
        end
        if (flush) begin
            busy_d = '0;
            for (int r = 0; r < NREG; r++) begin
                tag_d[r] = '0;
            end
            for (int s = 0; s < NCKPT; s++) begin
                ck_busy_d[s] = '0;
                for (int r = 0; r < NREG; r++) begin
                    ck_tag_d[s][r] = '0;
                end
            end
        end else if (ckpt_restore) begin
            busy_d = ck_busy_d[ckpt_id];
            for (int r = 0; r < NREG; r++) begin
                tag_d[r] = ck_tag_d[ckpt_id][r];
            end
        end else if (ckpt_save) begin
            ck_busy_d[ckpt_id] = busy_d;
            for (int r = 0; r < NREG; r++) begin
                ck_tag_d[ckpt_id][r] = tag_d[r];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                tag_q[r] <= '0;
            end
            for (int s = 0; s < NCKPT; s++) begin
                ck_busy_q[s] <= '0;
                for (int r = 0; r < NREG; r++) begin
                    ck_tag_q[s][r] <= '0;
                end
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < NREG; r++) begin
                tag_q[r] <= tag_d[r];
            end
            for (int s = 0; s < NCKPT; s++) begin
                ck_busy_q[s] <= ck_busy_d[s];
                for (int r = 0; r < NREG; r++) begin
                    ck_tag_q[s][r] <= ck_tag_d[s][r];
                end
            end
        end
    end

    logic [REGW-1:0] rs;
    logic            sb;
    logic [ROB-1:0]  st;

    always_comb begin
        src1_busy = '0;
        src2_busy = '0;
        src1_rob  = '0;
        src2_rob  = '0;
        rs        = '0;
        sb        = 1'b0;
        st        = '0;
        for (int i = 0; i < RENAME; i++) begin
            for (int p = 0; p < 2; p++) begin
                rs = (p == 0) ? rs1_w[i] : rs2_w[i];
                sb = 1'b0;
                st = '0;
                if (rs != '0) begin
                    sb = busy_q[rs] & ~lclr[rs];
                    st = tag_q[rs];
                    for (int j = 0; j < RENAME; j++) begin
                        if (j < i && ren_valid[j] && rd_w[j] == rs) begin
                            sb = 1'b1;
                            st = rob_w[j];
                        end
                    end
                end
                if (!sb) begin
                    st = '0;
                end
                if (p == 0) begin
                    src1_busy[i]         = sb;
                    src1_rob[i*ROB +: ROB] = st;
                end else begin
                    src2_busy[i]         = sb;
                    src2_rob[i*ROB +: ROB] = st;
                end
            end
        end
    end

    assign busy_vec = busy_q;

endmodule
